// File: rtl/fsk_pkg.sv
// Shared definitions for the FSK frame sequencer and the matching receiver side.
package fsk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SYNC,
    ST_PAY,
    ST_GUARD
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_PRE  = 2'd1;
  localparam logic [1:0] PH_SYNC = 2'd2;
  localparam logic [1:0] PH_PAY  = 2'd3;

  localparam logic [7:0] DEF_SYNC_WORD = 8'hB8;
  localparam int         DEF_DIV       = 16;

  // Index width must cover the longest segment; never narrower than one bit.
  function automatic int idx_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/fsk_bit_timer.sv
// Mod-DIV bit-period counter with clear/enable, flagging the first and last cycle of a bit.
module fsk_bit_timer #(
  parameter int DIV = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic boundary,
  output logic first
);

  localparam int TW = $clog2(DIV);

  logic [TW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == TW'(DIV - 1)) ? '0 : count + 1'b1;
    end
  end

  assign boundary = (count == TW'(DIV - 1));
  assign first    = (count == '0);

endmodule

// File: rtl/fsk_frame_ctrl.sv
// FSK frame sequencer: preamble, sync word, paced payload from the bit source, then guard time.
module fsk_frame_ctrl
  import fsk_pkg::*;
#(
  parameter int         DIV       = DEF_DIV,
  parameter int         PRE_LEN   = 8,
  parameter int         SYNC_LEN  = 8,
  parameter logic [7:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int         PAY_LEN   = 64,
  parameter int         GUARD_LEN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       src_bit,
  output logic       src_step,
  output logic       tone_sel,
  output logic       tx_on,
  output logic       busy,
  output logic       done,
  output logic [1:0] phase,
  output logic [7:0] frame_cnt
);

  localparam int IW = idx_width(PRE_LEN, SYNC_LEN, PAY_LEN, GUARD_LEN);

  state_t          state, state_d;
  logic [IW-1:0]   idx, idx_d, idx_n;
  logic            tone_d, tx_d, step_d, busy_d, done_d;
  logic [1:0]      phase_d;
  logic [7:0]      cnt_d;
  logic [2:0]      sync_sel;
  logic            boundary, first, tmr_clr, tmr_en;

  assign tmr_clr = (state == ST_IDLE) || abort;
  assign tmr_en  = (state != ST_IDLE);

  fsk_bit_timer #(.DIV(DIV)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .boundary (boundary),
    .first    (first)
  );

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    tone_d   = tone_sel;
    tx_d     = tx_on;
    step_d   = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    phase_d  = phase;
    cnt_d    = frame_cnt;
    idx_n    = idx + 1'b1;
    sync_sel = 3'(SYNC_LEN - 1 - int'(idx_n));

    if (abort && state != ST_IDLE) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      tone_d  = 1'b0;
      tx_d    = 1'b0;
      busy_d  = 1'b0;
      phase_d = PH_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          // The timer is parked at zero while idle, so a frame always starts on a fresh bit.
          if (start && !abort && first) begin
            state_d = ST_PRE;
            idx_d   = '0;
            tone_d  = 1'b1;
            tx_d    = 1'b1;
            busy_d  = 1'b1;
            phase_d = PH_PRE;
          end
        end
        ST_PRE: begin
          if (boundary) begin
            if (idx == IW'(PRE_LEN - 1)) begin
              state_d = ST_SYNC;
              idx_d   = '0;
              tone_d  = SYNC_WORD[SYNC_LEN-1];
              phase_d = PH_SYNC;
            end else begin
              idx_d  = idx_n;
              tone_d = ~idx_n[0];
            end
          end
        end
        ST_SYNC: begin
          if (boundary) begin
            if (idx == IW'(SYNC_LEN - 1)) begin
              state_d = ST_PAY;
              idx_d   = '0;
              tone_d  = src_bit;
              step_d  = (PAY_LEN > 1) ? 1'b1 : 1'b0;
              phase_d = PH_PAY;
            end else begin
              idx_d  = idx_n;
              tone_d = SYNC_WORD[sync_sel];
            end
          end
        end
        ST_PAY: begin
          // src_step is registered, so it is raised on the edge that opens each payload bit.
          if (boundary) begin
            if (idx == IW'(PAY_LEN - 1)) begin
              state_d = ST_GUARD;
              idx_d   = '0;
              tone_d  = 1'b0;
              tx_d    = 1'b0;
              phase_d = PH_IDLE;
            end else begin
              idx_d  = idx_n;
              tone_d = src_bit;
              step_d = (idx_n != IW'(PAY_LEN - 1));
            end
          end
        end
        ST_GUARD: begin
          if (boundary) begin
            if (idx == IW'(GUARD_LEN - 1)) begin
              state_d = ST_IDLE;
              idx_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              cnt_d   = frame_cnt + 8'd1;
            end else begin
              idx_d = idx_n;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          tone_d  = 1'b0;
          tx_d    = 1'b0;
          busy_d  = 1'b0;
          phase_d = PH_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      tone_sel  <= 1'b0;
      tx_on     <= 1'b0;
      src_step  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      phase     <= PH_IDLE;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      tone_sel  <= tone_d;
      tx_on     <= tx_d;
      src_step  <= step_d;
      busy      <= busy_d;
      done      <= done_d;
      phase     <= phase_d;
      frame_cnt <= cnt_d;
    end
  end

endmodule
